// File: rtl/weight_seq_ctrl_if.sv
// Weight beat stream between a weight source and weight_seq_ctrl.
//   s_valid : source offers a 256-bit weight beat
//   s_ready : sink can take a beat this cycle
//   s_data  : weight beat, 9-bit signed weights packed LSB-first
// A beat transfers on a rising clk edge with s_valid and s_ready both high.
interface weight_seq_ctrl_if;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/weight_seq_ctrl.sv
// Weight sequencer / class-sum controller for a Tsetlin-style clause bank.
// Loads a BEATS-beat weight image into the bank, then on request scans the
// active clauses and accumulates the bank weights of the clauses that fired.
//   clk, rst      : rising-edge clock, asynchronous active-low reset
//   beat          : weight beat stream (slave side)
//   start         : single-cycle scoring request, honoured only in READY
//   clauses       : active clause count (clamped to CLAUSEN), sampled on start
//   clause_fire   : clause outputs, sampled on start
//   wa_valid/wa_offset/wa_data : one-cycle bank write of an accepted beat
//   wa_clause_no  : bank read index; weight_in returns one cycle later
//   wa_clauses    : latched clause count
//   weight_in     : registered bank weight
//   sum, done     : class sum and its one-cycle completion pulse
//   loaded, busy  : complete image held / scan in progress
module weight_seq_ctrl #(
  parameter int CLAUSEN = 10,
  parameter int BEATS   = 5,
  localparam int CW     = $clog2(CLAUSEN) + 1
) (
  input  logic                clk,
  input  logic                rst,
  weight_seq_ctrl_if.slave    beat,
  input  logic                start,
  input  logic [CW-1:0]       clauses,
  input  logic [CLAUSEN-1:0]  clause_fire,
  output logic                wa_valid,
  output logic [2:0]          wa_offset,
  output logic [255:0]        wa_data,
  output logic [CW-1:0]       wa_clause_no,
  output logic [CW-1:0]       wa_clauses,
  input  logic signed [8:0]   weight_in,
  output logic signed [15:0]  sum,
  output logic                done,
  output logic                loaded,
  output logic                busy
);

  typedef enum logic [2:0] {EMPTY, LOAD, READY, SCAN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [2:0]           beat_cnt;
  logic [CW-1:0]        clauses_q;
  logic [CLAUSEN-1:0]   fire_q;
  logic [CLAUSEN-1:0]   fire_sh;
  logic                 acc_en;     // weight_in of the previous read index counts
  logic                 beat_acc;
  logic                 start_acc;
  logic                 image_end;
  logic                 scan_last;
  logic [CW-1:0]        clauses_clamped;

  assign image_end       = (beat_cnt == 3'(BEATS - 1));
  assign scan_last       = (clauses_q == '0) || (wa_clause_no == clauses_q - CW'(1));
  assign clauses_clamped = (clauses > CW'(CLAUSEN)) ? CW'(CLAUSEN) : clauses;
  assign fire_sh         = fire_q >> wa_clause_no;

  // s_ready stays high in READY even when start is present; start simply
  // wins and the beat is not taken that cycle.
  assign beat.s_ready = rst && (state_q inside {EMPTY, LOAD, READY});
  assign busy         = (state_q == SCAN) || (state_q == DRAIN);
  assign wa_clauses   = clauses_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create order races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    beat_acc  = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      EMPTY, LOAD: begin
        if (beat.s_valid) begin
          beat_acc = 1'b1;
          state_d  = image_end ? READY : LOAD;
        end
      end
      READY: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = SCAN;
        end else if (beat.s_valid) begin
          // A beat here begins a fresh image; beat_cnt is 0 after the wrap.
          beat_acc = 1'b1;
          state_d  = image_end ? READY : LOAD;
        end
      end
      SCAN:    if (scan_last) state_d = DRAIN;
      DRAIN:   state_d = READY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: the latched clause mask and write data are plain registers, not a
  // memory array, so they are cleared by reset along with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt     <= '0;
      wa_valid     <= 1'b0;
      wa_offset    <= '0;
      wa_data      <= '0;
      wa_clause_no <= '0;
      clauses_q    <= '0;
      fire_q       <= '0;
      acc_en       <= 1'b0;
      sum          <= '0;
      done         <= 1'b0;
      loaded       <= 1'b0;
    end else begin
      wa_valid <= beat_acc;
      done     <= 1'b0;
      acc_en   <= 1'b0;

      if (beat_acc) begin
        wa_offset <= beat_cnt;
        wa_data   <= beat.s_data;
        beat_cnt  <= image_end ? 3'd0 : beat_cnt + 3'd1;
        loaded    <= image_end;
      end

      if (start_acc) begin
        clauses_q    <= clauses_clamped;
        fire_q       <= clause_fire;
        wa_clause_no <= '0;
      end

      // The bank answers one cycle after the index, so the fire bit of the
      // index driven now is carried forward to qualify next cycle's weight.
      if (state_q == SCAN) begin
        acc_en <= (clauses_q != '0) && fire_sh[0];
        if (!scan_last) wa_clause_no <= wa_clause_no + CW'(1);
      end

      if (start_acc)   sum <= '0;
      else if (acc_en) sum <= sum + $signed({{7{weight_in[8]}}, weight_in});

      if (state_q == DRAIN) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed self-checking bench for weight_seq_ctrl (CLAUSEN=10, BEATS=5).
// A small registered bank model returns wtab[wa_clause_no] one cycle later.
module tb_weight_seq_ctrl;
  localparam int CW = $clog2(10) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CW-1:0]     clauses;
  logic [9:0]        clause_fire;
  logic              wa_valid;
  logic [2:0]        wa_offset;
  logic [255:0]      wa_data;
  logic [CW-1:0]     wa_clause_no;
  logic [CW-1:0]     wa_clauses;
  logic signed [8:0] weight_in = '0;
  logic signed [15:0] sum;
  logic              done;
  logic              loaded;
  logic              busy;

  logic signed [8:0] wtab [0:31];
  int                n_checks = 0;
  int                n_fails  = 0;
  logic [2:0]        exp_off  = 3'd0;
  logic              exp_loaded = 1'b0;

  weight_seq_ctrl_if beat_if ();

  weight_seq_ctrl #(.CLAUSEN(10), .BEATS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .beat         (beat_if),
    .start        (start),
    .clauses      (clauses),
    .clause_fire  (clause_fire),
    .wa_valid     (wa_valid),
    .wa_offset    (wa_offset),
    .wa_data      (wa_data),
    .wa_clause_no (wa_clause_no),
    .wa_clauses   (wa_clauses),
    .weight_in    (weight_in),
    .sum          (sum),
    .done         (done),
    .loaded       (loaded),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Registered weight bank model.
  always @(posedge clk) weight_in <= wtab[wa_clause_no];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer (or withhold) one beat at this negedge, check the write next negedge.
  task automatic beat_step(input logic v, input logic [255:0] d);
    beat_if.s_valid = v;
    beat_if.s_data  = d;
    @(negedge clk);
    check("beat_wa_valid", wa_valid, v);
    if (v) begin
      check("beat_offset", wa_offset, exp_off);
      check("beat_data", wa_data, d);
      exp_loaded = (exp_off == 3'd4);
      exp_off    = (exp_off == 3'd4) ? 3'd0 : exp_off + 3'd1;
    end
    check("beat_loaded", loaded, exp_loaded);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, beat_if.s_ready, 0);
    check({tag, "_wa_valid"}, wa_valid, 0);
    check({tag, "_wa_offset"}, wa_offset, 0);
    check({tag, "_wa_data"}, wa_data, 0);
    check({tag, "_clause_no"}, wa_clause_no, 0);
    check({tag, "_wa_clauses"}, wa_clauses, 0);
    check({tag, "_sum"}, $unsigned(sum), 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_loaded"}, loaded, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 32; i++) wtab[i] = '0;
    rst = 1'b0; start = 1'b0; clauses = '0; clause_fire = '0;
    beat_if.s_valid = 1'b0; beat_if.s_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check("empty_s_ready", beat_if.s_ready, 1);

    // start in EMPTY is ignored
    start = 1'b1; clauses = 5'd3; clause_fire = '1;
    @(negedge clk);
    start = 1'b0;
    check("empty_start_busy", busy, 0);
    check("empty_start_wa_clauses", wa_clauses, 0);

    // Five back-to-back beats 0xA..0xE
    for (int i = 0; i < 5; i++) beat_step(1'b1, 256'(10 + i));
    beat_step(1'b0, '0);

    // Gapped stream 1,0,1,1,0,1,1 reloads a new image with offsets 0..4
    beat_step(1'b1, 256'h100);
    beat_step(1'b0, 256'h1FF);
    beat_step(1'b1, 256'h102);
    beat_step(1'b1, 256'h103);
    beat_step(1'b0, 256'h1FF);
    beat_step(1'b1, 256'h105);
    beat_step(1'b1, {128'hDEAD_BEEF, 128'h106});

    // Scan: clauses=4, fire=1011, w=+5,-3,+7,+100 -> 5-3+100 = 102;
    // start is presented together with a beat, which must not be written.
    wtab[0] = 9'sd5; wtab[1] = -9'sd3; wtab[2] = 9'sd7; wtab[3] = 9'sd100;
    start = 1'b1; clauses = 5'd4; clause_fire = 10'b00_0000_1011;
    beat_if.s_valid = 1'b1; beat_if.s_data = 256'hBAD;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; beat_if.s_valid = 1'b0;
        check("start_wins_no_write", wa_valid, 0);
        check("scan_s_ready", beat_if.s_ready, 0);
        check("scan_wa_clauses", wa_clauses, 4);
      end
      if (c <= 4) check("scan4_clause_no", wa_clause_no, c - 1);
      check("scan4_busy", busy, c <= 5);
      check("scan4_done", done, c == 6);
    end
    check("scan4_sum", $unsigned(sum), 16'd102);
    check("scan4_loaded", loaded, 1);

    // clauses=0: completes with sum 0 even though every clause fires
    start = 1'b1; clauses = 5'd0; clause_fire = '1;
    @(negedge clk);
    start = 1'b0;
    check("zero_busy", busy, 1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("zero_done_seen", found, 1);
    check("zero_sum", $unsigned(sum), 0);

    // clauses=15 clamps to 10; a start mid-scan is ignored; sum = 1+..+10
    for (int i = 0; i < 10; i++) wtab[i] = 9'(i + 1);
    for (int i = 10; i < 16; i++) wtab[i] = 9'sd50;
    start = 1'b1; clauses = 5'd15; clause_fire = '1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == 3);
      clauses = (c == 3) ? 5'd1 : 5'd15;
      if (c <= 10) check("clamp_clause_no", wa_clause_no, c - 1);
      check("clamp_done", done, c == 12);
    end
    start = 1'b0;
    check("clamp_wa_clauses", wa_clauses, 10);
    check("clamp_sum", $unsigned(sum), 16'd55);

    // Reset during SCAN at k=2 abandons everything
    start = 1'b1; clauses = 5'd4; clause_fire = '1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("pre_reset_clause_no", wa_clause_no, 2);
    rst = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_s_ready", beat_if.s_ready, 1);
    start = 1'b1; clauses = 5'd1; clause_fire = 10'd1;
    @(negedge clk);
    start = 1'b0;
    check("post_reset_start_ignored", busy, 0);
    check("post_reset_loaded", loaded, 0);

    // Reload, then a one-clause scan of weight -7
    exp_off = 3'd0; exp_loaded = 1'b0;
    for (int i = 0; i < 5; i++) beat_step(1'b1, 256'(32 + i));
    beat_if.s_valid = 1'b0;
    wtab[0] = -9'sd7;
    start = 1'b1; clauses = 5'd1; clause_fire = 10'd1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("one_done", done, c == 3);
    end
    check("one_sum", $unsigned(sum), 16'hFFF9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
